// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one UART_TX among NREQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a SEND watchdog that aborts a stuck frame and sets sticky ERR.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic              CLK100MHZ,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_LAST,
  output logic [NREQ-1:0]   ACK,
  output logic [NREQ-1:0]   GRANT,
  output logic              TX_EN,
  output logic [DW-1:0]     TX_DATA,
  input  logic              TX_DONE,
  output logic              BUSY,
  output logic              ERR
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, g_q, g_d, pick;
  logic [NREQ-1:0] ack_q, ack_d, grant_q, grant_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0] burst_q, burst_d;
  logic tx_en_q, tx_en_d, last_q, last_d, busy_q, found, timeout;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic err_q;
  assign timeout = state_q == SEND && !TX_DONE && wd_q == WW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK100MHZ or negedge RESET_N)
    if (!RESET_N) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= state_q == SEND ? wd_q + WW'(1) : '0;
      err_q <= err_q | timeout;
    end
  assign ERR = err_q;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
  assign ERR = 1'b0;
`endif

  // first asserted requester searching upward from rr+1, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    for (int k = 0; k < NREQ; k++)
      if (!found && REQ[IW'((int'(rr_q) + 1 + k) % NREQ)]) begin
        found = 1'b1;
        pick = IW'((int'(rr_q) + 1 + k) % NREQ);
      end
  end

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    g_d = g_q;
    grant_d = grant_q;
    ack_d = '0;
    tx_en_d = 1'b0;
    data_d = data_q;
    last_d = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: if (found) begin
        g_d = pick;
        grant_d = NREQ'(1) << pick;
        burst_d = '0;
        state_d = LOAD;
      end
      LOAD: if (!REQ[g_q]) begin
        grant_d = '0;
        state_d = IDLE;
      end else begin
        data_d = REQ_DATA[g_q*DW +: DW];
        last_d = REQ_LAST[g_q];
        ack_d = grant_q;
        burst_d = burst_q + 8'd1;
        state_d = SEND;
      end
      SEND: if (TX_DONE) state_d = GAP;
      else if (timeout) begin
        rr_d = g_q;
        grant_d = '0;
        state_d = IDLE;
      end else tx_en_d = 1'b1;
      GAP: if (last_q || burst_q == 8'(MAX_BURST) || !REQ[g_q]) begin
        rr_d = g_q;
        grant_d = '0;
        state_d = IDLE;
      end else state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      rr_q <= IW'(NREQ - 1);
      g_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      tx_en_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      burst_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      g_q <= g_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      tx_en_q <= tx_en_d;
      data_q <= data_d;
      last_q <= last_d;
      burst_q <= burst_d;
      busy_q <= state_d != IDLE;
    end

  assign ACK = ack_q;
  assign GRANT = grant_q;
  assign TX_EN = tx_en_q;
  assign TX_DATA = data_q;
  assign BUSY = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests of arbitration order, packet lock, burst limit, async reset and watchdog.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_last = '0, ack, grant;
  logic [N*8-1:0] req_data = '0;
  logic tx_en, tx_done = 1'b0, busy, err;
  logic [7:0] tx_data;
  int total = 0, bad = 0;
  logic [7:0] fq[N][$];
  bit lq[N][$];
  logic [11:0] tx_log[$];
  logic [3:0] ack_log[$];
  int uart_dly = 10, ucnt = 0;
  bit tx_prev = 1'b0, hold = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(N), .DW(8), .MAX_BURST(16), .TIMEOUT_CYCLES(100)) dut (
    .CLK100MHZ(clk), .RESET_N(rst_n), .REQ(req), .REQ_DATA(req_data), .REQ_LAST(req_last),
    .ACK(ack), .GRANT(grant), .TX_EN(tx_en), .TX_DATA(tx_data), .TX_DONE(tx_done),
    .BUSY(busy), .ERR(err));

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req[i] = fq[i].size() != 0;
      req_data[i*8 +: 8] = 8'h00;
      req_last[i] = 1'b0;
      if (req[i]) begin
        req_data[i*8 +: 8] = fq[i][0];
        req_last[i] = lq[i][0];
      end
    end
  endfunction

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // one clock: observe at the falling edge, pop on ACK, model UART_TX frame timing
  task automatic tick();
    @(negedge clk);
    if (|ack) begin
      ack_log.push_back(ack);
      for (int i = 0; i < N; i++)
        if (ack[i] && fq[i].size() != 0) begin
          void'(fq[i].pop_front());
          void'(lq[i].pop_front());
        end
    end
    tx_done = 1'b0;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) tx_done = 1'b1;
    end
    if (tx_en && !tx_prev) begin
      tx_log.push_back({grant, tx_data});
      if (!hold) ucnt = uart_dly;
    end
    tx_prev = tx_en;
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    fq[r].push_back(d);
    lq[r].push_back(l);
  endtask

  task automatic run_until(input int ntx, output bit ok);
    int n = 0;
    while (!(tx_log.size() >= ntx && !busy && fifos_empty()) && n < 5000) begin
      tick();
      n++;
    end
    ok = n < 5000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      lq[i].delete();
    end
    ucnt = 0;
    tx_done = 1'b0;
    tx_prev = 1'b0;
    hold = 1'b0;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tx_log.delete();
    ack_log.delete();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({ack, grant, tx_en, tx_data, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {ack, grant, tx_en, tx_data, busy, err});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({grant, busy} !== '0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=0", {grant, busy});
    end
  endtask

  task automatic test_single();
    int n = 0;
    uart_dly = 8680;
    push(0, 8'h41, 1'b1);
    drive();
    tick();
    total++;
    if (grant !== 4'b0001 || ack !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_plus1 grant=%b ack=%b busy=%b exp 0001/0000/1", grant, ack, busy);
    end
    tick();
    total++;
    if (ack !== 4'b0001 || tx_en !== 1'b0) begin
      bad++;
      $display("FAIL single_plus2 ack=%b tx_en=%b exp 0001/0", ack, tx_en);
    end
    tick();
    total++;
    if (tx_en !== 1'b1 || tx_data !== 8'h41 || ack !== 4'b0000) begin
      bad++;
      $display("FAIL single_plus3 tx_en=%b data=%h ack=%b exp 1/41/0000", tx_en, tx_data, ack);
    end
    while (!tx_done && n < 9000) begin
      tick();
      n++;
    end
    total++;
    if (tx_done !== 1'b1 || tx_en !== 1'b1) begin
      bad++;
      $display("FAIL single_send done=%b tx_en=%b exp 1/1", tx_done, tx_en);
    end
    tick();
    total++;
    if (tx_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gap tx_en=%b busy=%b exp 0/1", tx_en, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000 || ack_log.size() != 1) begin
      bad++;
      $display("FAIL single_idle busy=%b grant=%b acks=%0d exp 0/0000/1", busy, grant, ack_log.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    uart_dly = 10;
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      push(i, 8'hB0 + 8'(i), 1'b1);
    end
    drive();
    run_until(8, ok);
    total++;
    if (!ok || tx_log.size() != 8 || ack_log.size() != 8) begin
      bad++;
      $display("FAIL rr_count ok=%b tx=%0d acks=%0d exp 1/8/8", ok, tx_log.size(), ack_log.size());
    end else
      for (int k = 0; k < 8; k++) begin
        eg = 4'b0001 << (k % 4);
        ed = (k < 4 ? 8'hA0 : 8'hB0) + 8'(k % 4);
        total++;
        if (tx_log[k] !== {eg, ed} || ack_log[k] !== eg) begin
          bad++;
          $display("FAIL rr_byte%0d got=%h ack=%b exp=%h", k, tx_log[k], ack_log[k], {eg, ed});
        end
      end
  endtask

  task automatic test_max_burst();
    bit ok;
    logic [11:0] e;
    tx_log.delete();
    ack_log.delete();
    for (int k = 0; k < 20; k++) push(2, 8'h60 + 8'(k), k == 19);
    push(3, 8'h77, 1'b1);
    drive();
    run_until(21, ok);
    total++;
    if (!ok || tx_log.size() != 21 || ack_log.size() != 21) begin
      bad++;
      $display("FAIL burst_count ok=%b tx=%0d acks=%0d exp 1/21/21", ok, tx_log.size(), ack_log.size());
    end else
      for (int k = 0; k < 21; k++) begin
        e = k < 16 ? {4'b0100, 8'h60 + 8'(k)} : k == 16 ? {4'b1000, 8'h77} : {4'b0100, 8'h60 + 8'(k - 1)};
        total++;
        if (tx_log[k] !== e) begin
          bad++;
          $display("FAIL burst_byte%0d got=%h exp=%h", k, tx_log[k], e);
        end
      end
  endtask

  task automatic test_req_drop();
    bit ok;
    tx_log.delete();
    ack_log.delete();
    for (int k = 0; k < 3; k++) push(1, 8'h51 + 8'(k), 1'b0);
    drive();
    run_until(3, ok);
    total++;
    if (!ok || tx_log.size() != 3 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL drop_release ok=%b tx=%0d grant=%b exp 1/3/0000", ok, tx_log.size(), grant);
    end else
      for (int k = 0; k < 3; k++) begin
        total++;
        if (tx_log[k] !== {4'b0010, 8'h51 + 8'(k)}) begin
          bad++;
          $display("FAIL drop_byte%0d got=%h exp=%h", k, tx_log[k], {4'b0010, 8'h51 + 8'(k)});
        end
      end
    push(0, 8'h0A, 1'b1);
    push(2, 8'h2A, 1'b1);
    drive();
    run_until(5, ok);
    total++;
    if (!ok || tx_log.size() != 5 || ack_log.size() != 5 || tx_log[3] !== 12'h42A || tx_log[4] !== 12'h10A) begin
      bad++;
      $display("FAIL drop_next ok=%b tx=%0d acks=%0d b3=%h b4=%h exp 1/5/5/42a/10a",
               ok, tx_log.size(), ack_log.size(), tx_log[3], tx_log[4]);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    bit ok;
    tx_log.delete();
    ack_log.delete();
    uart_dly = 500;
    push(0, 8'hEE, 1'b1);
    drive();
    while (!tx_en && n < 10) begin
      tick();
      n++;
    end
    repeat (5) tick();
    total++;
    if (tx_en !== 1'b1 || grant !== 4'b0001) begin
      bad++;
      $display("FAIL areset_presend tx_en=%b grant=%b exp 1/0001", tx_en, grant);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ack, grant, tx_en, tx_data, busy, err} !== '0) begin
      bad++;
      $display("FAIL areset_outputs got=%h exp=0", {ack, grant, tx_en, tx_data, busy, err});
    end
    ucnt = 0;
    tx_done = 1'b0;
    tx_prev = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    uart_dly = 10;
    push(3, 8'h3C, 1'b1);
    drive();
    tick();
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL areset_grant got=%b exp=1000", grant);
    end
    tick();
    total++;
    if (ack !== 4'b1000) begin
      bad++;
      $display("FAIL areset_ack got=%b exp=1000", ack);
    end
    tick();
    total++;
    if (tx_en !== 1'b1 || tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL areset_tx tx_en=%b data=%h exp 1/3c", tx_en, tx_data);
    end
    run_until(2, ok);
    total++;
    if (!ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL areset_finish ok=%b busy=%b exp 1/0", ok, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    tx_log.delete();
    ack_log.delete();
    hold = 1'b1;
    push(0, 8'h99, 1'b1);
    drive();
    repeat (3) tick();
    total++;
    if (tx_en !== 1'b1 || tx_data !== 8'h99) begin
      bad++;
      $display("FAIL wd_start tx_en=%b data=%h exp 1/99", tx_en, tx_data);
    end
    repeat (98) tick();
    total++;
    if (tx_en !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL wd_before tx_en=%b err=%b exp 1/0", tx_en, err);
    end
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    total++;
    if (tx_en !== 1'b0 || err !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wd_abort tx_en=%b err=%b grant=%b busy=%b exp 0/1/0000/0", tx_en, err, grant, busy);
    end
    hold = 1'b0;
    repeat (5) tick();
    push(2, 8'hD2, 1'b1);
    drive();
    run_until(2, ok);
    total++;
    if (!ok || tx_log.size() != 2 || tx_log[1] !== 12'h4D2 || err !== 1'b1 || ack_log.size() != 2) begin
      bad++;
      $display("FAIL wd_next ok=%b tx=%0d b1=%h err=%b acks=%0d exp 1/2/4d2/1/2",
               ok, tx_log.size(), tx_log[1], err, ack_log.size());
    end
`else
    total++;
    if (tx_en !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL nowd_hold tx_en=%b err=%b exp 1/0", tx_en, err);
    end
    repeat (200) tick();
    total++;
    if (tx_en !== 1'b1 || err !== 1'b0 || grant !== 4'b0001) begin
      bad++;
      $display("FAIL nowd_wait tx_en=%b err=%b grant=%b exp 1/0/0001", tx_en, err, grant);
    end
    hold = 1'b0;
    ucnt = 1;
    run_until(1, ok);
    total++;
    if (!ok || busy !== 1'b0 || err !== 1'b0 || ack_log.size() != 1) begin
      bad++;
      $display("FAIL nowd_finish ok=%b busy=%b err=%b acks=%0d exp 1/0/0/1", ok, busy, err, ack_log.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_req_drop();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
